// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader constants and FSM state encoding
package imem_loader_pkg;
  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: packs MSB-first bytes into 32-bit words
// Ports: clock/reset_n clock and async active-low reset; i_clear restarts the byte count;
//        i_valid/i_byte byte input; o_word assembled word (including the current byte);
//        o_ready high on the cycle the 4th byte of a word is presented
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_ready
);
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;
  // The word is combined with the byte on the bus so the loader can register it on the same edge
  assign o_word  = {r_shift, i_byte};
  assign o_ready = i_valid && r_cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader writing 32-bit words into instruction RAM
// Ports: clock/reset_n clock and async active-low reset; rx_data/rx_valid received bytes;
//        mem_write_enable/mem_address/mem_data RAM write port; cpu_hold keeps the CPU in reset;
//        load_done one-cycle success pulse; load_error sticky checksum failure; busy frame in progress
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 8,
  parameter int         WORD_WIDTH  = 32,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic                  busy
);
  state_t                r_state, w_state;
  logic [7:0]            r_count, r_sum;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic                  r_we, r_hold, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_data;
  logic [31:0]           w_word;
  logic                  w_ready, w_last;
  imem_loader_byte_packer u_packer (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (rx_valid && r_state == COUNT),
    .i_valid (rx_valid && r_state == DATA),
    .i_byte  (rx_data),
    .o_word  (w_word),
    .o_ready (w_ready)
  );
  // COUNT byte 0 wraps to 255 here, giving a 256-word frame
  assign w_last = r_word_idx == ADDR_WIDTH'(r_count - 8'd1);
  always_comb begin
    w_state = r_state;
    if (rx_valid)
      case (r_state)
        IDLE:  w_state = rx_data == HEADER_BYTE ? COUNT : IDLE;
        COUNT: w_state = DATA;
        DATA:  w_state = w_ready && w_last ? CHECK : DATA;
        CHECK: w_state = IDLE;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_sum      <= '0;
      r_word_idx <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      if (rx_valid)
        case (r_state)
          IDLE: if (rx_data == HEADER_BYTE) begin
            r_hold <= 1'b1;
            r_err  <= 1'b0;
          end
          COUNT: begin
            r_count    <= rx_data;
            r_sum      <= '0;
            r_word_idx <= '0;
          end
          DATA: begin
            r_sum <= r_sum + rx_data;
            if (w_ready) begin
              r_we       <= 1'b1;
              r_addr     <= r_word_idx;
              r_data     <= w_word;
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
          CHECK: if (rx_data == r_sum) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        endcase
    end
  end
  assign mem_write_enable = r_we;
  assign mem_address      = r_addr;
  assign mem_data         = r_data;
  assign cpu_hold         = r_hold;
  assign load_done        = r_done;
  assign load_error       = r_err;
  assign busy             = r_state != IDLE;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus multi-cycle sequences for imem_loader
module tb_imem_loader;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mem_write_enable, cpu_hold, load_done, load_error, busy;
  logic [7:0]  mem_address;
  logic [31:0] mem_data;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  fb[$];
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [7:0]  a;
    logic [31:0] data;
    logic        h, dn, er, b;
  } vec_t;
  vec_t vecs[$];
  imem_loader dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .cpu_hold         (cpu_hold),
    .load_done        (load_done),
    .load_error       (load_error),
    .busy             (busy)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (mem_write_enable) begin
      wa.push_back(mem_address);
      wd.push_back(mem_data);
    end
    if (load_done) done_cnt++;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic add(input logic v, input logic [7:0] d, input logic we, input logic [7:0] a,
                     input logic [31:0] data, input logic h, input logic dn, input logic er, input logic b);
    vec_t t;
    t.v = v; t.d = d; t.we = we; t.a = a; t.data = data; t.h = h; t.dn = dn; t.er = er; t.b = b;
    vecs.push_back(t);
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask
  task automatic send_fb(input int gap);
    foreach (fb[i]) send(fb[i], gap);
  endtask
  task automatic two_word(input int gap, input string tag);
    int base, dbase;
    base  = wa.size();
    dbase = done_cnt;
    fb = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    send_fb(gap);
    @(negedge clock);
    chk({tag, "_writes"}, wa.size() - base, 2);
    if (wa.size() - base == 2) begin
      chk({tag, "_addr0"}, wa[base], 0);
      chk({tag, "_data0"}, wd[base], 32'h01020304);
      chk({tag, "_addr1"}, wa[base+1], 1);
      chk({tag, "_data1"}, wd[base+1], 32'h05060708);
    end
    chk({tag, "_done"}, done_cnt - dbase, 1);
    chk({tag, "_hold"}, cpu_hold, 0);
  endtask
  initial begin
    localparam logic [31:0] D = 32'hDEADBEEF;
    int base, dbase;
    logic [7:0] sum;
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(1, 8'h37, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'hA5, 0, 0, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'h01, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'hDE, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'hAD, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'hBE, 0, 0, 0, 1, 0, 0, 1);
    add(1, 8'hEF, 1, 0, D, 1, 0, 0, 1);
    add(0, 8'h00, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'h38, 0, 0, D, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, D, 0, 0, 0, 0);
    add(1, 8'hA5, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'h01, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hDE, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hAD, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hBE, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hEF, 1, 0, D, 1, 0, 0, 1);
    add(1, 8'h39, 0, 0, D, 1, 0, 1, 0);
    add(0, 8'h00, 0, 0, D, 1, 0, 1, 0);
    add(1, 8'h12, 0, 0, D, 1, 0, 1, 0);
    add(1, 8'hA5, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'h01, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hDE, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hAD, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hBE, 0, 0, D, 1, 0, 0, 1);
    add(1, 8'hEF, 1, 0, D, 1, 0, 0, 1);
    add(1, 8'h38, 0, 0, D, 0, 1, 0, 0);
    repeat (2) @(negedge clock);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clock);
    rx_data  = vecs[0].d;
    rx_valid = vecs[0].v;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      chk($sformatf("v%0d_we", i), mem_write_enable, vecs[i].we);
      chk($sformatf("v%0d_addr", i), mem_address, vecs[i].a);
      chk($sformatf("v%0d_data", i), mem_data, vecs[i].data);
      chk($sformatf("v%0d_hold", i), cpu_hold, vecs[i].h);
      chk($sformatf("v%0d_done", i), load_done, vecs[i].dn);
      chk($sformatf("v%0d_err", i), load_error, vecs[i].er);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].b);
      rx_valid = i + 1 < vecs.size() ? vecs[i+1].v : 1'b0;
      rx_data  = i + 1 < vecs.size() ? vecs[i+1].d : 8'h00;
    end
    rx_valid = 1'b0;
    @(negedge clock);
    base  = wa.size();
    dbase = done_cnt;
    sum   = 8'h00;
    send(8'hA5, 0);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++)
      repeat (4) begin
        send(8'(i), 0);
        sum += 8'(i);
      end
    chk("full_busy_before_sum", busy, 1);
    send(sum, 0);
    @(negedge clock);
    chk("full_writes", wa.size() - base, 256);
    if (wa.size() - base == 256) begin
      chk("full_first_addr", wa[base], 0);
      chk("full_mid_data", wd[base+128], 32'h80808080);
      chk("full_last_addr", wa[base+255], 255);
      chk("full_last_data", wd[base+255], 32'hFFFFFFFF);
    end
    chk("full_done", done_cnt - dbase, 1);
    chk("full_busy", busy, 0);
    chk("full_err", load_error, 0);
    two_word(0, "b2b");
    two_word(3, "gap");
    base = wa.size();
    fb = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_fb(0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_writes_before", wa.size() - base, 1);
    chk("mid_rst_addr", mem_address, 0);
    chk("mid_rst_data", mem_data, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", load_error, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    base  = wa.size();
    dbase = done_cnt;
    fb = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h40};
    send_fb(0);
    @(negedge clock);
    chk("post_rst_writes", wa.size() - base, 1);
    if (wa.size() - base == 1) begin
      chk("post_rst_addr", wa[base], 0);
      chk("post_rst_data", wd[base], 32'hCAFEBABE);
    end
    chk("post_rst_done", done_cnt - dbase, 1);
    chk("post_rst_hold", cpu_hold, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
